// File: rtl/muldiv_wb_arbiter_pkg.sv
// Shared op codes, arbiter state encoding and writeback entry type for the MUL/DIV arbiter.
// wb_entry_t widths are fixed by MULDIV_XLEN / MULDIV_TID_BITS; the top defaults to the same values.
package muldiv_wb_arbiter_pkg;

    localparam int MULDIV_XLEN     = 64;
    localparam int MULDIV_TID_BITS = 3;

    localparam logic [7:0] OP_MUL    = 8'd83;
    localparam logic [7:0] OP_MULW   = 8'd87;
    localparam logic [7:0] OP_DIV    = 8'd88;
    localparam logic [7:0] OP_REMUW  = 8'd95;
    localparam logic [7:0] OP_CLMUL  = 8'd155;
    localparam logic [7:0] OP_CLMULR = 8'd157;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_DIV_BUSY = 2'd1,
        ARB_DIV_HOLD = 2'd2
    } muldiv_arb_state_e;

    typedef struct packed {
        logic                       valid;
        logic [MULDIV_XLEN-1:0]     data;
        logic [MULDIV_TID_BITS-1:0] trans_id;
    } wb_entry_t;

    function automatic logic is_mul_op(input logic [7:0] op);
        return ((op >= OP_MUL) && (op <= OP_MULW)) || ((op >= OP_CLMUL) && (op <= OP_CLMULR));
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op >= OP_DIV) && (op <= OP_REMUW);
    endfunction

endpackage

// File: rtl/muldiv_wb_arbiter_hold_reg.sv
// One-entry hold register for a divider result that lost writeback arbitration.
// Priority: flush > capture > clear; state visible the cycle after the request.
module muldiv_hold_reg
    import muldiv_wb_arbiter_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      capture_i,
    input  logic      clear_i,
    input  wb_entry_t entry_i,
    output wb_entry_t entry_o
);

    wb_entry_t r_entry;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_entry <= '0;
        end else if (flush_i) begin
            r_entry.valid <= 1'b0;
        end else if (capture_i) begin
            r_entry <= entry_i;
        end else if (clear_i) begin
            r_entry.valid <= 1'b0;
        end
    end

    assign entry_o = r_entry;

endmodule

// File: rtl/muldiv_wb_arbiter.sv
// Routes issued MUL/DIV ops and merges both result streams onto one writeback port.
// Optional MULDIV_ARB_PERF_EN adds saturating collision / divide-busy cycle counters.
module muldiv_wb_arbiter
    import muldiv_wb_arbiter_pkg::*;
#(
    parameter int XLEN          = MULDIV_XLEN,
    parameter int TRANS_ID_BITS = MULDIV_TID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     fu_valid_i,
    input  logic [7:0]               operation_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     mult_ready_o,
    output logic                     div_ready_o,
    output logic                     mul_issue_o,
    output logic                     div_issue_o,
    input  logic                     div_in_ready_i,
    input  logic                     mult_valid_i,
    input  logic [XLEN-1:0]          mult_result_i,
    input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
    input  logic                     div_valid_i,
    input  logic [XLEN-1:0]          div_result_i,
    input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
    output logic                     div_out_ready_o,
    output logic                     result_valid_o,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o
`ifdef MULDIV_ARB_PERF_EN
    ,
    output logic [31:0]              collision_cnt_o,
    output logic [31:0]              div_busy_cnt_o
`endif
);

    muldiv_arb_state_e r_state, w_state_nxt;
    wb_entry_t         w_hold, w_div_entry, w_wb;
    logic              w_is_mul, w_is_div, w_capture, w_clear;
    logic              w_unused_tid;

    // The issue id travels with the op into the datapaths; the arbiter only sees it on return.
    assign w_unused_tid = ^trans_id_i;

    assign w_is_mul = is_mul_op(operation_i);
    assign w_is_div = is_div_op(operation_i);

    assign mult_ready_o    = 1'b1;
    assign mul_issue_o     = fu_valid_i & w_is_mul;
    assign div_issue_o     = fu_valid_i & w_is_div & (r_state == ARB_IDLE) & ~flush_i;
    assign div_ready_o     = (r_state == ARB_IDLE) & div_in_ready_i;
    assign div_out_ready_o = (r_state != ARB_DIV_HOLD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ARB_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        if (flush_i) begin
            w_state_nxt = ARB_IDLE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (div_issue_o && div_in_ready_i) w_state_nxt = ARB_DIV_BUSY;
                end
                ARB_DIV_BUSY: begin
                    if (div_valid_i) begin
                        w_capture   = mult_valid_i;
                        w_state_nxt = mult_valid_i ? ARB_DIV_HOLD : ARB_IDLE;
                    end
                end
                ARB_DIV_HOLD: begin
                    if (!mult_valid_i) begin
                        w_clear     = 1'b1;
                        w_state_nxt = ARB_IDLE;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    assign w_div_entry = '{valid: 1'b1, data: div_result_i, trans_id: div_trans_id_i};

    muldiv_hold_reg u_hold (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .capture_i (w_capture),
        .clear_i   (w_clear),
        .entry_i   (w_div_entry),
        .entry_o   (w_hold)
    );

    // A flushed divide result is accepted but never written back; mult results always pass.
    always_comb begin
        w_wb = '0;
        if (mult_valid_i) begin
            w_wb = '{valid: 1'b1, data: mult_result_i, trans_id: mult_trans_id_i};
        end else if ((r_state == ARB_DIV_HOLD) && w_hold.valid && !flush_i) begin
            w_wb = w_hold;
        end else if ((r_state == ARB_DIV_BUSY) && div_valid_i && !flush_i) begin
            w_wb = w_div_entry;
        end
    end

    assign result_valid_o    = w_wb.valid;
    assign result_o          = w_wb.data;
    assign result_trans_id_o = w_wb.trans_id;

`ifdef MULDIV_ARB_PERF_EN
    logic [31:0] r_collision_cnt, r_div_busy_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_collision_cnt <= '0;
            r_div_busy_cnt  <= '0;
        end else begin
            if ((r_state == ARB_DIV_HOLD) && mult_valid_i && (r_collision_cnt != '1))
                r_collision_cnt <= r_collision_cnt + 32'd1;
            if ((r_state != ARB_IDLE) && (r_div_busy_cnt != '1))
                r_div_busy_cnt <= r_div_busy_cnt + 32'd1;
        end
    end

    assign collision_cnt_o = r_collision_cnt;
    assign div_busy_cnt_o  = r_div_busy_cnt;
`endif

    // A divider result with no divide outstanding points at a flush/accounting bug upstream.
    a_no_orphan_div_result: assert property (
        @(posedge clk_i) disable iff (rst_i) !((r_state == ARB_IDLE) && div_valid_i)
    );

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed bench for muldiv_wb_arbiter: decode, routing, collisions, hold, flush and async reset.
module tb_muldiv_wb_arbiter;

    localparam int XLEN = 64;
    localparam int TIDB = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i, fu_valid_i, div_in_ready_i;
    logic [7:0]      operation_i;
    logic [TIDB-1:0] trans_id_i;
    logic            mult_ready_o, div_ready_o, mul_issue_o, div_issue_o, div_out_ready_o;
    logic            mult_valid_i, div_valid_i, result_valid_o;
    logic [XLEN-1:0] mult_result_i, div_result_i, result_o;
    logic [TIDB-1:0] mult_trans_id_i, div_trans_id_i, result_trans_id_o;
`ifdef MULDIV_ARB_PERF_EN
    logic [31:0]     collision_cnt_o, div_busy_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    muldiv_wb_arbiter #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .fu_valid_i        (fu_valid_i),
        .operation_i       (operation_i),
        .trans_id_i        (trans_id_i),
        .mult_ready_o      (mult_ready_o),
        .div_ready_o       (div_ready_o),
        .mul_issue_o       (mul_issue_o),
        .div_issue_o       (div_issue_o),
        .div_in_ready_i    (div_in_ready_i),
        .mult_valid_i      (mult_valid_i),
        .mult_result_i     (mult_result_i),
        .mult_trans_id_i   (mult_trans_id_i),
        .div_valid_i       (div_valid_i),
        .div_result_i      (div_result_i),
        .div_trans_id_i    (div_trans_id_i),
        .div_out_ready_o   (div_out_ready_o),
        .result_valid_o    (result_valid_o),
        .result_o          (result_o),
        .result_trans_id_o (result_trans_id_o)
`ifdef MULDIV_ARB_PERF_EN
        ,
        .collision_cnt_o   (collision_cnt_o),
        .div_busy_cnt_o    (div_busy_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        flush_i = 0; fu_valid_i = 0; operation_i = 8'd0; trans_id_i = '0;
        mult_valid_i = 0; mult_result_i = '0; mult_trans_id_i = '0;
        div_valid_i = 0; div_result_i = '0; div_trans_id_i = '0;
        div_in_ready_i = 1;
    endtask

    // Advance to 1 time unit past the next rising edge; inputs are then driven mid-cycle.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mult(input logic [63:0] res, input logic [TIDB-1:0] id);
        mult_valid_i = 1; mult_result_i = res; mult_trans_id_i = id;
    endtask

    task automatic divres(input logic [63:0] res, input logic [TIDB-1:0] id);
        div_valid_i = 1; div_result_i = res; div_trans_id_i = id;
    endtask

    task automatic check_wb(input string tag, input logic v, input logic [63:0] d, input logic [TIDB-1:0] id);
        check({tag, ".vld"}, 64'(result_valid_o), 64'(v));
        check({tag, ".dat"}, result_o, d);
        check({tag, ".id"}, 64'(result_trans_id_o), 64'(id));
    endtask

    // Issue a divide from IDLE and leave the arbiter in DIV_BUSY.
    task automatic issue_div(input logic [7:0] op);
        quiet();
        fu_valid_i = 1; operation_i = op; trans_id_i = 3'd1;
        #1;
        check("issue.div_issue", 64'(div_issue_o), 64'd1);
        step();
        quiet();
    endtask

    initial begin
        quiet();
        div_in_ready_i = 0;
        rst_i = 1;
        #3;
        check("rst.mult_ready", 64'(mult_ready_o), 64'd1);
        check("rst.div_ready", 64'(div_ready_o), 64'd0);
        check("rst.issue", 64'({mul_issue_o, div_issue_o}), 64'd0);
        check_wb("rst.wb", 1'b0, 64'd0, 3'd0);
`ifdef MULDIV_ARB_PERF_EN
        check("rst.coll_cnt", 64'(collision_cnt_o), 64'd0);
        check("rst.busy_cnt", 64'(div_busy_cnt_o), 64'd0);
`endif
        #4 rst_i = 0;
        step();

        // Decode boundaries and multiplier pass-through.
        quiet();
        fu_valid_i = 1; operation_i = 8'd83; trans_id_i = 3'd2;
        mult(64'h15, 3'd2);
        #1;
        check("mul.issue", 64'({mul_issue_o, div_issue_o}), 64'b10);
        check_wb("mul.wb", 1'b1, 64'h15, 3'd2);
        operation_i = 8'd156; #1;
        check("clmulh.issue", 64'({mul_issue_o, div_issue_o}), 64'b10);
        operation_i = 8'd82; #1;
        check("op82.issue", 64'({mul_issue_o, div_issue_o}), 64'b00);
        operation_i = 8'd96; #1;
        check("op96.issue", 64'({mul_issue_o, div_issue_o}), 64'b00);
        operation_i = 8'd158; #1;
        check("op158.issue", 64'({mul_issue_o, div_issue_o}), 64'b00);
        step();
        quiet(); #1;
        check("op96.still_idle", 64'(div_ready_o), 64'd1);
        check_wb("idle.wb", 1'b0, 64'd0, 3'd0);

        // Flush blocks a divide issue.
        fu_valid_i = 1; operation_i = 8'd89; flush_i = 1; #1;
        check("flush.div_issue", 64'(div_issue_o), 64'd0);
        step();
        quiet(); #1;
        check("flush.no_busy", 64'(div_ready_o), 64'd1);

        // Plain divide, forwarded with zero latency.
        issue_div(8'd88);
        #1;
        check("busy.div_ready", 64'(div_ready_o), 64'd0);
        check("busy.out_ready", 64'(div_out_ready_o), 64'd1);
        fu_valid_i = 1; operation_i = 8'd90; #1;
        check("busy.no_2nd_div", 64'(div_issue_o), 64'd0);
        fu_valid_i = 0;
        divres(64'h7, 3'd5); #1;
        check_wb("div.wb", 1'b1, 64'h7, 3'd5);
        step();
        quiet(); #1;
        check("div.back_idle", 64'(div_ready_o), 64'd1);

        // Single collision: mult wins, divide result one cycle later.
        issue_div(8'd92);
        divres(64'hA, 3'd4); mult(64'hB, 3'd1); #1;
        check_wb("coll.mult_wins", 1'b1, 64'hB, 3'd1);
        check("coll.accept", 64'(div_out_ready_o), 64'd1);
        step();
        quiet(); #1;
        check_wb("coll.held", 1'b1, 64'hA, 3'd4);
        check("coll.hold_out_rdy", 64'(div_out_ready_o), 64'd0);
        step(); #1;
        check("coll.idle", 64'(div_ready_o), 64'd1);
        check_wb("coll.after", 1'b0, 64'd0, 3'd0);

        // Hold across three back-to-back mult results.
        issue_div(8'd95);
        divres(64'h1234, 3'd6); mult(64'h100, 3'd0);
        step();
        for (int i = 1; i <= 3; i++) begin
            quiet();
            mult(64'h100 + 64'(i), 3'(i)); #1;
            check_wb($sformatf("hold3.m%0d", i), 1'b1, 64'h100 + 64'(i), 3'(i));
            check($sformatf("hold3.out_rdy%0d", i), 64'(div_out_ready_o), 64'd0);
            step();
        end
        quiet(); #1;
        check_wb("hold3.emit", 1'b1, 64'h1234, 3'd6);
        step(); #1;
        check("hold3.idle", 64'(div_ready_o), 64'd1);

        // Flush while holding: mult still passes, held result is lost.
        issue_div(8'd91);
        divres(64'h55, 3'd7); mult(64'h66, 3'd3);
        step();
        quiet();
        flush_i = 1; mult(64'h77, 3'd2); #1;
        check_wb("flush.mult_pass", 1'b1, 64'h77, 3'd2);
        step();
        quiet(); #1;
        check_wb("flush.no_held", 1'b0, 64'd0, 3'd0);
        check("flush.div_ready", 64'(div_ready_o), 64'd1);
        check("flush.out_ready", 64'(div_out_ready_o), 64'd1);
`ifdef MULDIV_ARB_PERF_EN
        check("perf.coll_cnt", 64'(collision_cnt_o), 64'd4);
`endif

        // Asynchronous reset in DIV_BUSY.
        issue_div(8'd93);
        #1;
        check("arst.pre_busy", 64'(div_ready_o), 64'd0);
        div_in_ready_i = 0;
        #1 rst_i = 1;
        #1;
        check("arst.mult_ready", 64'(mult_ready_o), 64'd1);
        check("arst.div_ready", 64'(div_ready_o), 64'd0);
        check_wb("arst.wb", 1'b0, 64'd0, 3'd0);
`ifdef MULDIV_ARB_PERF_EN
        check("arst.coll_cnt", 64'(collision_cnt_o), 64'd0);
        check("arst.busy_cnt", 64'(div_busy_cnt_o), 64'd0);
`endif
        div_in_ready_i = 1; #1;
        check("arst.idle", 64'(div_ready_o), 64'd1);
        step();
        rst_i = 0;
        step();
        #1;
        check("arst.post_idle", 64'(div_ready_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
